// File: rtl/simple_processor.sv
// simple_processor: multicycle 8-register processor with mv/mvt/ALU ops driven by a T0-T3 FSM.
module simple_processor (
  input  logic        clk,
  input  logic        reset,
  input  logic        run,
  input  logic [15:0] din,
  output logic        done
);
  typedef enum logic [1:0] {T0, T1, T2, T3} state_t;
  state_t state, next;
  logic [15:0] r [8];
  logic [15:0] ir, a, g, y, alu, wdata;
  logic [2:0]  op, x;
  logic        single, wr;
  assign op     = ir[15:13];
  assign x      = ir[11:9];
  assign y      = ir[12] ? {7'b0, ir[8:0]} : r[ir[2:0]];
  assign single = (op == 3'b000) || (op == 3'b001) || (op == 3'b111);
  // Carry and borrow fall off the top; no flags are kept.
  assign alu = op == 3'b010 ? a + y :
               op == 3'b011 ? a - y :
               op == 3'b100 ? a & y :
               op == 3'b101 ? a | y : a ^ y;
  always_comb begin
    next  = state;
    done  = 1'b0;
    wr    = 1'b0;
    wdata = g;
    case (state)
      T0: next = run ? T1 : T0;
      T1: begin
        next  = single ? T0 : T2;
        done  = single;
        wr    = (op == 3'b000) || (op == 3'b001);
        wdata = op == 3'b001 ? {ir[7:0], 8'h00} : y;
      end
      T2: next = T3;
      T3: begin
        next = T0;
        done = 1'b1;
        wr   = 1'b1;
      end
    endcase
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= T0;
      ir    <= '0;
      a     <= '0;
      g     <= '0;
      for (int i = 0; i < 8; i++) r[i] <= '0;
    end else begin
      state <= next;
      if (state == T0 && run) ir <= din;
      if (state == T1) a <= r[x];
      if (state == T2) g <= alu;
      if (wr) r[x] <= wdata;
    end
endmodule

// File: tb/tb_simple_processor.sv
// tb_simple_processor: directed instruction vectors with hand-computed register results and done timing.
module tb_simple_processor;
  logic        clk = 0, reset = 0, run = 0;
  logic [15:0] din = '0;
  logic        done;
  int checks = 0, errors = 0;

  simple_processor dut (.clk(clk), .reset(reset), .run(run), .din(din), .done(done));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic exec(input string tag, input logic [15:0] instr, input int lat);
    int n;
    @(negedge clk) begin run = 1; din = instr; end
    @(negedge clk) begin run = 0; din = 16'hFFFF; end
    n = 1;
    while (!done && n < 10) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_lat"}, n, lat);
    @(negedge clk);
    check({tag, "_done_low"}, done, 0);
  endtask

  initial begin
    #12;
    check("rst_done", done, 0);
    check("rst_state", dut.state, 0);
    check("rst_r0", dut.r[0], 0);
    check("rst_r7", dut.r[7], 0);
    @(negedge clk) reset = 1;
    din = 16'h1ABC;
    repeat (3) @(negedge clk);
    check("idle_ir", dut.ir, 0);
    check("idle_done", done, 0);

    exec("mv_imm", 16'h10FF, 1);  check("mv_imm_r0", dut.r[0], 16'h00FF);
    exec("mv_r7", 16'h1E05, 1);   check("mv_r7", dut.r[7], 16'h0005);
    exec("add_reg", 16'h40FF, 3); check("add_reg_r0", dut.r[0], 16'h0104);
    check("add_reg_r7", dut.r[7], 16'h0005);
    exec("mvt", 16'h20FF, 1);     check("mvt_r0", dut.r[0], 16'hFF00);
    exec("mv_zero", 16'h1000, 1); check("mv_zero_r0", dut.r[0], 16'h0000);
    exec("sub_wrap", 16'h60FF, 3); check("sub_wrap_r0", dut.r[0], 16'hFFFB);
    exec("mvt2", 16'h20FF, 1);
    exec("or_imm", 16'hB0FF, 3);  check("or_imm_r0", dut.r[0], 16'hFFFF);
    exec("add_wrap", 16'h5001, 3); check("add_wrap_r0", dut.r[0], 16'h0000);
    exec("mv_r2", 16'h15AB, 1);   check("mv_r2", dut.r[2], 16'h01AB);
    exec("xor_imm", 16'hD4FF, 3); check("xor_r2", dut.r[2], 16'h0154);
    exec("and_reg", 16'h8407, 3); check("and_r2", dut.r[2], 16'h0004);
    exec("mv_reg", 16'h0602, 1);  check("mv_reg_r3", dut.r[3], 16'h0004);
    exec("nop", 16'hE6FF, 1);     check("nop_r3", dut.r[3], 16'h0004);
    exec("mv_d8", 16'h19FF, 1);   check("mv_d8_r4", dut.r[4], 16'h01FF);

    begin : back_to_back
      int n;
      @(negedge clk) begin run = 1; din = 16'h1203; end
      n = 0;
      while (!done && n < 10) begin
        @(negedge clk);
        n++;
      end
      check("b2b_first_lat", n, 1);
      din = 16'h4201;
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!done && n < 10);
      check("b2b_gap", n, 4);
      check("b2b_ir", dut.ir, 16'h4201);
      run = 0;
      @(negedge clk);
      check("b2b_r1", dut.r[1], 16'h0006);
      check("b2b_done_low", done, 0);
    end

    @(negedge clk) begin run = 1; din = 16'h5001; end
    @(negedge clk) run = 0;
    @(negedge clk);
    check("mid_state_t2", dut.state, 2);
    reset = 0;
    #1;
    check("mid_state", dut.state, 0);
    check("mid_r7", dut.r[7], 0);
    check("mid_r1", dut.r[1], 0);
    check("mid_a", dut.a, 0);
    check("mid_g", dut.g, 0);
    check("mid_ir", dut.ir, 0);
    check("mid_done", done, 0);
    repeat (2) @(negedge clk);
    check("mid_done_hold", done, 0);
    check("mid_r0_hold", dut.r[0], 0);
    reset = 1;
    exec("post_rst", 16'h1E05, 1); check("post_rst_r7", dut.r[7], 16'h0005);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout got running expected finished");
    $fatal(1);
  end
endmodule

// File: doc/simple_processor.md
SIMPLE_PROCESSOR -- requirements
Module: simple_processor

Interface
REQ-001 SHALL have port: clk  input  1  single system clock; all state changes on the rising edge.
REQ-002 SHALL have port: reset  input  1  asynchronous, active-low reset; 0 clears all state immediately, independent of clk.
REQ-003 SHALL have port: run  input  1  start request; sampled only in state T0.
REQ-004 SHALL have port: din  input  16  instruction word; sampled only in T0 when run=1.
REQ-005 SHALL have port: done  output  1  high for exactly one cycle, the final cycle of each instruction.

Function
REQ-006 SHALL decode the instruction as III=din[15:13] opcode, M=din[12] immediate flag, XXX=din[11:9] destination rX, D=din[8:0] immediate or source field.
REQ-007 SHALL contain eight 16-bit registers r0..r7, a 16-bit IR, a 16-bit A register and a 16-bit G register; all are hierarchically visible for verification.
REQ-008 SHALL define the operand Y as {7'b0, D} when M=1 and as register r[D[2:0]] when M=0; D[8:3] are ignored when M=0.
REQ-009 SHALL implement opcode 000 (mv) as rX <= Y.
REQ-010 SHALL implement opcode 001 (mvt) as rX <= {D[7:0], 8'h00}, ignoring M.
REQ-011 SHALL implement opcode 010 (add) as rX <= rX + Y.
REQ-012 SHALL implement opcode 011 (sub) as rX <= rX - Y.
REQ-013 SHALL implement opcode 100 (and) as rX <= rX & Y.
REQ-014 SHALL implement opcode 101 (or) as rX <= rX | Y.
REQ-015 SHALL implement opcode 110 (xor) as rX <= rX ^ Y.
REQ-016 SHALL treat opcode 111 as a no-op: no register write, done asserted in T1.
REQ-017 SHALL perform all arithmetic modulo 2^16: carry-out and borrow are discarded, and no flags are produced.
REQ-018 SHALL use a four-state FSM: T0 idle/fetch, T1, T2, T3.
REQ-019 T0: if run=1, IR <= din and go to T1; otherwise stay in T0 with no state change.
REQ-020 T1 for mv, mvt or 111: perform the write at the clock edge, assert done, go to T0 (2-cycle instruction including fetch).
REQ-021 T1 for an ALU opcode (010-110): A <= rX, go to T2.
REQ-022 T2: G <= A op Y, go to T3.
REQ-023 T3: rX <= G, assert done, go to T0 (4-cycle instruction including fetch).
REQ-024 done SHALL be a combinational Moore-style decode of the state and IR, and SHALL be 0 in every other state.
REQ-025 run and din SHALL be ignored in T1-T3; a new instruction can be fetched on the edge immediately after the done cycle.
REQ-026 When rX equals the source register (e.g. add r3,r3), the pre-instruction value SHALL be used for both operands.

Reset
REQ-027 reset=0 SHALL asynchronously force: FSM to T0, r0..r7=0, IR=0, A=0, G=0, done=0.
REQ-028 Reset asserted mid-instruction SHALL abandon that instruction with no partial register write.
REQ-029 After reset deasserts, the first fetch SHALL occur at the first rising edge with run=1.

Verification
REQ-030 Reset, then din=16'h10FF with run=1 for one cycle -> r0=16'h00FF after T1; done high for one cycle, 1 cycle after the fetch edge.
REQ-031 Reset, then din=16'h20FF (mvt r0) -> r0=16'hFF00; done in T1.
REQ-032 mv r7,#5 (16'h1E05), then din=16'h40FF (add r0,r0,r7) with r0=16'h00FF -> r0=16'h0104; done exactly in T3; r7 unchanged.
REQ-033 With r0=0 and r7=5, din=16'h60FF (sub r0,r0,r7) -> r0=16'hFFFB (wrap-around); with r0=16'hFFFF, add #1 -> r0=16'h0000.
REQ-034 Assert reset=0 during T2 of an add -> FSM returns to T0 immediately, all registers read 0, done stays 0.
REQ-035 Hold run=1 continuously over two back-to-back instructions -> the second fetch occurs on the edge after the first done; run high during T1-T3 causes no extra fetch.
